// File: rtl/l1_cache_ctrl.sv
// Direct-mapped, write-through / no-allocate L1 cache controller with
// line refill from a word-wide backing memory and read hit/miss statistics.
module l1_cache_ctrl #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4,
    parameter int CNT_W          = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   addr,
    input  logic                ce_n,
    input  logic                oe_n,
    input  logic                we_n,
    input  logic                bw,
    input  logic [DATA_W-1:0]   wdata_i,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                hold_o,
    input  logic                flush_i,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack,
    output logic [CNT_W-1:0]    hit_cnt,
    output logic [CNT_W-1:0]    miss_cnt
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int OFS_W = (OFF_W > 0) ? OFF_W : 1;
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - 2 - OFF_W - IDX_W;

    typedef enum logic [1:0] {IDLE, REFILL, DONE, WRITE} state_t;

    state_t            state;
    logic [DATA_W-1:0] data_mem [LINES][WORDS_PER_LINE];
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [LINES-1:0]  valid;
    logic [ADDR_W-1:0] req_addr;
    logic [OFS_W-1:0]  cnt;
    logic              flush_pend;
    logic [DATA_W-1:0] w_data;
    logic [NB-1:0]     w_be;

    function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] a);
        return IDX_W'(a >> (2 + OFF_W));
    endfunction

    function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] a);
        return TAG_W'(a >> (2 + OFF_W + IDX_W));
    endfunction

    function automatic logic [OFS_W-1:0] off_of(input logic [ADDR_W-1:0] a);
        return OFS_W'((a >> 2) & ADDR_W'(WORDS_PER_LINE - 1));
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + CNT_W'(1);
    endfunction

    logic [IDX_W-1:0]  cur_idx, req_idx;
    logic [OFS_W-1:0]  cur_off, req_off;
    logic              hit, access, is_wr, is_rd, flush_now, last_word;
    logic [NB-1:0]     cpu_be;
    logic [DATA_W-1:0] cpu_wd;

    assign cur_idx   = idx_of(addr);
    assign cur_off   = off_of(addr);
    assign req_idx   = idx_of(req_addr);
    assign req_off   = off_of(req_addr);
    assign hit       = valid[cur_idx] && (tag_mem[cur_idx] == tag_of(addr));
    assign access    = !ce_n && (!oe_n || !we_n);
    // write strobe wins when both strobes are low
    assign is_wr     = access && !we_n;
    assign is_rd     = access && we_n;
    assign flush_now = flush_i || flush_pend;
    assign last_word = (cnt == OFS_W'(WORDS_PER_LINE - 1));
    assign cpu_be    = bw ? '1 : (NB'(1) << addr[1:0]);
    assign cpu_wd    = bw ? wdata_i : {NB{wdata_i[7:0]}};

    always_comb begin
        hold_o    = 1'b0;
        rdata_o   = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = req_addr & ~ADDR_W'(3);
        mem_wdata = w_data;
        mem_be    = '0;
        case (state)
            IDLE: begin
                if (flush_now || is_wr) begin
                    hold_o = 1'b1;
                end else if (is_rd) begin
                    if (hit) rdata_o = data_mem[cur_idx][cur_off];
                    else     hold_o  = 1'b1;
                end
            end
            REFILL: begin
                mem_req  = 1'b1;
                hold_o   = 1'b1;
                mem_be   = '1;
                mem_addr = (req_addr & ~ADDR_W'(WORDS_PER_LINE * 4 - 1))
                         | (ADDR_W'(cnt) << 2);
            end
            DONE: rdata_o = data_mem[req_idx][req_off];
            WRITE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                hold_o  = 1'b1;
                mem_be  = w_be;
            end
            default: ;
        endcase
        if (!reset_n) begin
            hold_o  = 1'b0;
            rdata_o = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            valid      <= '0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
            flush_pend <= 1'b0;
            cnt        <= '0;
            req_addr   <= '0;
            w_data     <= '0;
            w_be       <= '0;
        end else begin
            if (state != IDLE && flush_i) flush_pend <= 1'b1;
            case (state)
                IDLE: begin
                    if (flush_now) begin
                        valid      <= '0;
                        flush_pend <= 1'b0;
                    end else if (is_wr) begin
                        req_addr <= addr;
                        w_data   <= cpu_wd;
                        w_be     <= cpu_be;
                        state    <= WRITE;
                    end else if (is_rd) begin
                        if (hit) begin
                            hit_cnt <= sat_inc(hit_cnt);
                        end else begin
                            miss_cnt       <= sat_inc(miss_cnt);
                            req_addr       <= addr;
                            cnt            <= '0;
                            valid[cur_idx] <= 1'b0;
                            state          <= REFILL;
                        end
                    end
                end
                REFILL: begin
                    if (mem_ack) begin
                        cnt <= cnt + OFS_W'(1);
                        if (last_word) begin
                            valid[req_idx] <= 1'b1;
                            state          <= DONE;
                        end
                    end
                end
                DONE:  state <= IDLE;
                WRITE: if (mem_ack) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // storage arrays carry no reset; valid bits alone qualify their contents
    always_ff @(posedge clk) begin
        if (state == IDLE && !flush_now && is_wr && hit) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (cpu_be[i]) data_mem[cur_idx][cur_off][8*i +: 8] <= cpu_wd[8*i +: 8];
            end
        end
        if (state == REFILL && mem_ack) begin
            data_mem[req_idx][cnt] <= mem_rdata;
            if (last_word) tag_mem[req_idx] <= tag_of(req_addr);
        end
    end

endmodule

// File: tb/tb_l1_cache_ctrl.sv
// Bench for l1_cache_ctrl: directed vector table, hand-written reset/flush
// sequences and randomized traffic against a line-level reference model.
module tb_l1_cache_ctrl;

    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] addr = '0;
    logic        ce_n = 1'b1, oe_n = 1'b1, we_n = 1'b1, bw = 1'b1;
    logic [31:0] wdata_i = '0;
    logic [31:0] rdata_o;
    logic        hold_o;
    logic        flush_i = 1'b0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic [CW-1:0] hit_cnt, miss_cnt;

    always #5 clk = ~clk;

    l1_cache_ctrl #(.ADDR_W(32), .DATA_W(32), .LINES(16), .WORDS_PER_LINE(4), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n), .addr(addr), .ce_n(ce_n), .oe_n(oe_n), .we_n(we_n),
        .bw(bw), .wdata_i(wdata_i), .rdata_o(rdata_o), .hold_o(hold_o), .flush_i(flush_i),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // reference memory and cache model: one tracked line base per index
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] m_line [16];
    bit          m_valid [16];
    int          m_hit = 0, m_miss = 0;

    bit          stall_en = 1'b0;
    int          ack_count = 0;
    int          wr_count = 0;
    logic [31:0] wr_addr = '0, wr_data = '0;
    logic [3:0]  wr_be = '0;
    logic [31:0] rd_log [$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (ref_mem.exists(w)) return ref_mem[w];
        return {w[15:0], ~w[15:0]};
    endfunction

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
        return m;
    endfunction

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic model_read(input logic [31:0] a, output bit exp_hit);
        int ix;
        ix = int'(a[7:4]);
        exp_hit = m_valid[ix] && (m_line[ix] == (a & ~32'hF));
        if (exp_hit) m_hit = sat(m_hit);
        else begin
            m_miss = sat(m_miss);
            m_valid[ix] = 1'b1;
            m_line[ix]  = a & ~32'hF;
        end
    endtask

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic bwv);
        logic [31:0] w;
        w = mem_word(a);
        if (bwv) w = d;
        else     w[8*a[1:0] +: 8] = d[7:0];
        ref_mem[{a[31:2], 2'b00}] = w;
    endtask

    task automatic model_flush();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // backing memory: answers at the falling edge so ack is stable for the rising edge
    always @(negedge clk) begin
        mem_ack = 1'b0;
        if (reset_n && mem_req && (!stall_en || $urandom_range(0, 2) != 0)) begin
            mem_ack = 1'b1;
            ack_count++;
            if (mem_we) begin
                wr_addr = mem_addr;
                wr_be   = mem_be;
                wr_data = mem_wdata;
                wr_count++;
            end else begin
                rd_log.push_back(mem_addr);
                mem_rdata = mem_word(mem_addr);
            end
        end
    end

    task automatic cpu_read(input logic [31:0] a, output int n, output logic [31:0] d);
        @(negedge clk);
        addr = a; ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b1;
        n = 0;
        #1;
        while (hold_o && n < 60) begin
            n++;
            @(negedge clk); #1;
        end
        d = rdata_o;
        @(negedge clk);
        ce_n = 1'b1; oe_n = 1'b1;
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d, input logic bwv,
                             output int h0, output int n, output int wc0);
        @(negedge clk);
        wc0 = wr_count;
        addr = a; ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1; bw = bwv; wdata_i = d;
        #1 h0 = int'(hold_o);
        @(negedge clk);
        ce_n = 1'b1; we_n = 1'b1; bw = 1'b1;
        n = 0;
        #1;
        while (hold_o && n < 60) begin
            n++;
            @(negedge clk); #1;
        end
    endtask

    task automatic cpu_nop(input logic [31:0] a, output int h);
        @(negedge clk);
        addr = a; ce_n = 1'b1; oe_n = 1'b0; we_n = 1'b0;
        #1 h = int'(hold_o);
        @(negedge clk);
        oe_n = 1'b1; we_n = 1'b1;
    endtask

    task automatic do_flush(input bit with_rd, input logic [31:0] a, output int h);
        @(negedge clk);
        flush_i = 1'b1;
        if (with_rd) begin addr = a; ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b1; end
        #1 h = int'(hold_o);
        @(negedge clk);
        flush_i = 1'b0; ce_n = 1'b1; oe_n = 1'b1;
    endtask

    typedef struct {
        int          op;      // 0 read, 1 word write, 2 byte write, 3 deselected strobes
        logic [31:0] a;
        logic [31:0] d;
        int          exp_n;   // hold cycles for reads
        logic [31:0] exp_v;   // read data, or write data on enabled lanes
        logic [3:0]  exp_be;
        logic [31:0] exp_maddr;
        int          exp_hit;
        int          exp_miss;
    } vec_t;

    vec_t tbl [13];

    initial begin
        int n, h0, wc0, lg0;
        logic [31:0] d, a;
        bit eh;

        tbl[0]  = '{0, 32'h0040_0004, 32'h0,         5, 32'h0004_FFFB, 4'h0, 32'h0,         0, 1};
        tbl[1]  = '{0, 32'h0040_0008, 32'h0,         0, 32'h0008_FFF7, 4'h0, 32'h0,         1, 1};
        tbl[2]  = '{3, 32'h0040_0008, 32'h0,         0, 32'h0,         4'h0, 32'h0,         1, 1};
        tbl[3]  = '{0, 32'h0040_0108, 32'h0,         5, 32'h0108_FEF7, 4'h0, 32'h0,         1, 2};
        tbl[4]  = '{0, 32'h0040_0004, 32'h0,         5, 32'h0004_FFFB, 4'h0, 32'h0,         1, 3};
        tbl[5]  = '{2, 32'h0040_0005, 32'h0000_00AB, 0, 32'h0000_AB00, 4'h2, 32'h0040_0004, 1, 3};
        tbl[6]  = '{0, 32'h0040_0004, 32'h0,         0, 32'h0004_ABFB, 4'h0, 32'h0,         2, 3};
        tbl[7]  = '{0, 32'h0040_000C, 32'h0,         0, 32'h000C_FFF3, 4'h0, 32'h0,         3, 3};
        tbl[8]  = '{1, 32'h0040_0008, 32'h1234_5678, 0, 32'h1234_5678, 4'hF, 32'h0040_0008, 3, 3};
        tbl[9]  = '{0, 32'h0040_0008, 32'h0,         0, 32'h1234_5678, 4'h0, 32'h0,         4, 3};
        tbl[10] = '{1, 32'h0040_0208, 32'hCAFE_F00D, 0, 32'hCAFE_F00D, 4'hF, 32'h0040_0208, 4, 3};
        tbl[11] = '{0, 32'h0040_0208, 32'h0,         5, 32'hCAFE_F00D, 4'h0, 32'h0,         4, 4};
        tbl[12] = '{0, 32'h0040_0004, 32'h0,         5, 32'h0004_ABFB, 4'h0, 32'h0,         4, 5};

        model_flush();

        // reset state
        #12;
        chk("rst_hold", hold_o, 1'b0);
        chk("rst_req", mem_req, 1'b0);
        chk("rst_we", mem_we, 1'b0);
        chk("rst_rdata", rdata_o, 32'h0);
        chk("rst_hit", hit_cnt, 0);
        chk("rst_miss", miss_cnt, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // directed vector table
        for (int i = 0; i < 13; i++) begin
            case (tbl[i].op)
                0: begin
                    lg0 = rd_log.size();
                    cpu_read(tbl[i].a, n, d);
                    model_read(tbl[i].a, eh);
                    chk("tbl_hold_cycles", n, tbl[i].exp_n);
                    chk("tbl_rdata", d, tbl[i].exp_v);
                    if (tbl[i].exp_n != 0) begin
                        chk("tbl_refill_len", rd_log.size() - lg0, 4);
                        for (int k = 0; k < 4; k++)
                            if (lg0 + k < rd_log.size())
                                chk("tbl_refill_addr", rd_log[lg0 + k], (tbl[i].a & ~32'hF) + 32'(4 * k));
                    end
                end
                1, 2: begin
                    cpu_write(tbl[i].a, tbl[i].d, tbl[i].op == 1, h0, n, wc0);
                    model_write(tbl[i].a, tbl[i].d, tbl[i].op == 1);
                    chk("tbl_wr_hold", h0, 1);
                    chk("tbl_wr_done", wr_count - wc0, 1);
                    chk("tbl_wr_addr", wr_addr, tbl[i].exp_maddr);
                    chk("tbl_wr_be", wr_be, tbl[i].exp_be);
                    chk("tbl_wr_data", wr_data & be_mask(tbl[i].exp_be), tbl[i].exp_v);
                end
                default: begin
                    cpu_nop(tbl[i].a, h0);
                    chk("tbl_nop_hold", h0, 0);
                end
            endcase
            chk("tbl_hit_cnt", hit_cnt, tbl[i].exp_hit);
            chk("tbl_miss_cnt", miss_cnt, tbl[i].exp_miss);
        end

        // flush arriving mid-refill is deferred to the next idle cycle
        fork
            cpu_read(32'h0040_0010, n, d);
            begin
                repeat (3) @(negedge clk);
                flush_i = 1'b1;
                @(negedge clk);
                flush_i = 1'b0;
            end
        join
        model_read(32'h0040_0010, eh);
        chk("fl_refill_cycles", n, 5);
        chk("fl_refill_data", d, mem_word(32'h0040_0010));
        #1 chk("fl_pending_hold", hold_o, 1'b1);
        model_flush();
        cpu_read(32'h0040_0010, n, d);
        model_read(32'h0040_0010, eh);
        chk("fl_reread_miss", n, 5);
        chk("fl_miss_cnt", miss_cnt, m_miss);

        // randomized traffic
        stall_en = 1'b1;
        for (int it = 0; it < 300; it++) begin
            int op;
            op = $urandom_range(0, 19);
            a = 32'h0040_0000 + 32'($urandom_range(0, 2) * 'h100)
              + 32'($urandom_range(0, 3) * 'h10) + 32'($urandom_range(0, 3) * 4);
            d = $urandom;
            if (op < 12) begin
                model_read(a, eh);
                cpu_read(a, n, d);
                chk("rnd_hit", n == 0, eh);
                if (!eh) chk("rnd_miss_min_hold", n >= 5, 1'b1);
                chk("rnd_rdata", d, mem_word(a));
            end else if (op < 18) begin
                logic bwv;
                logic [3:0] ebe;
                bwv = (op < 15);
                if (!bwv) a = a + 32'($urandom_range(0, 3));
                ebe = bwv ? 4'hF : (4'h1 << a[1:0]);
                cpu_write(a, d, bwv, h0, n, wc0);
                chk("rnd_wr_hold", h0, 1);
                chk("rnd_wr_done", wr_count - wc0, 1);
                chk("rnd_wr_addr", wr_addr, a & ~32'h3);
                chk("rnd_wr_be", wr_be, ebe);
                chk("rnd_wr_data", wr_data & be_mask(ebe),
                    (bwv ? d : ({24'h0, d[7:0]} << (8 * a[1:0]))) & be_mask(ebe));
                model_write(a, d, bwv);
            end else begin
                do_flush($urandom_range(0, 1) == 1, a, h0);
                chk("rnd_flush_hold", h0, 1);
                model_flush();
            end
            chk("rnd_hit_cnt", hit_cnt, m_hit);
            chk("rnd_miss_cnt", miss_cnt, m_miss);
        end
        stall_en = 1'b0;

        // conflicting reads drive the miss counter into saturation
        for (int k = 0; k < 20; k++) begin
            a = (k % 2 == 1) ? 32'h0040_0134 : 32'h0040_0034;
            model_read(a, eh);
            cpu_read(a, n, d);
            chk("sat_rdata", d, mem_word(a));
        end
        chk("sat_miss_ones", miss_cnt, CMAX);
        chk("sat_hit_cnt", hit_cnt, m_hit);

        // reset asserted in the middle of a refill
        wc0 = ack_count;
        @(negedge clk);
        addr = 32'h0040_0020; ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b1;
        n = 0;
        while (ack_count < wc0 + 2 && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        chk("mid_rst_acks_seen", n < 50, 1'b1);
        chk("mid_rst_req_before", mem_req, 1'b1);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_req", mem_req, 1'b0);
        chk("mid_rst_we", mem_we, 1'b0);
        chk("mid_rst_hold", hold_o, 1'b0);
        chk("mid_rst_rdata", rdata_o, 32'h0);
        chk("mid_rst_hit", hit_cnt, 0);
        chk("mid_rst_miss", miss_cnt, 0);
        @(negedge clk);
        ce_n = 1'b1; oe_n = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        model_flush();
        m_hit = 0; m_miss = 0;
        cpu_read(32'h0040_0020, n, d);
        model_read(32'h0040_0020, eh);
        chk("post_rst_miss_cycles", n, 5);
        chk("post_rst_rdata", d, mem_word(32'h0040_0020));
        chk("post_rst_miss_cnt", miss_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
        $fatal(1, "watchdog");
    end

endmodule
